// File: rtl/wb_port_arbiter_if.sv
// Bundled bus signals between N packed Wishbone masters, the arbiter and one shared target port.
// slave is the arbiter's view; master is the view of whatever drives the masters and the target.
// Slices are packed {port0, port1, ...}, so port 0 occupies the most-significant slice and bit.
interface wb_port_arbiter_if #(
    parameter int nr_of_ports = 3,
    parameter int adr_size    = 36,
    parameter int dat_size    = 36
);
    logic [nr_of_ports*adr_size-1:0] wb_adr_i;
    logic [nr_of_ports*dat_size-1:0] wb_dat_i;
    logic [nr_of_ports-1:0]          wb_stb_i;
    logic [nr_of_ports-1:0]          wb_cyc_i;
    logic [nr_of_ports*32-1:0]       wb_dat_o;
    logic [nr_of_ports-1:0]          wb_ack_o;
    logic [adr_size-1:0]             m_adr_o;
    logic [dat_size-1:0]             m_dat_o;
    logic                            m_stb_o;
    logic                            m_cyc_o;
    logic [31:0]                     m_dat_i;
    logic                            m_ack_i;
    logic [nr_of_ports-1:0]          grant_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, m_dat_i, m_ack_i,
        output wb_dat_o, wb_ack_o, m_adr_o, m_dat_o, m_stb_o, m_cyc_o, grant_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, m_dat_i, m_ack_i,
        input  wb_dat_o, wb_ack_o, m_adr_o, m_dat_o, m_stb_o, m_cyc_o, grant_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone target between nr_of_ports masters, grant held per bus cycle.
// Latency: grant registered one edge after a request; ack, read data and target signals are combinational.
// Backpressure: losers simply wait; a one-cycle IDLE bubble always separates two grants.
module wb_port_arbiter #(
    parameter int nr_of_ports = 3,
    parameter int adr_size    = 36,
    parameter int dat_size    = 36
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int IW = $clog2(nr_of_ports);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          last;

    logic [nr_of_ports-1:0] cyc_p;
    logic [nr_of_ports-1:0] stb_p;
    logic [nr_of_ports-1:0] req_p;
    logic [nr_of_ports-1:0] win_oh;
    logic                   any_req;
    logic [IW-1:0]          win;
    logic                   busy;
    logic [adr_size-1:0]    sel_adr;
    logic [dat_size-1:0]    sel_dat;
    logic                   sel_cyc;
    logic                   sel_stb;
    logic [2:0]             sel_cti;
    logic                   term;

    // Internal vectors are indexed by port number; the bus uses reversed bit order.
    always_comb begin
        cyc_p = '0;
        stb_p = '0;
        for (int i = 0; i < nr_of_ports; i++) begin
            cyc_p[i] = bus.wb_cyc_i[nr_of_ports-1-i];
            stb_p[i] = bus.wb_stb_i[nr_of_ports-1-i];
        end
        req_p = cyc_p & stb_p;
    end

    // Walk from the farthest candidate to the nearest so the first port after last wins.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int k = nr_of_ports; k >= 1; k--) begin
            int idx;
            idx = int'(last) + k;
            if (idx >= nr_of_ports)
                idx = idx - nr_of_ports;
            if (req_p[idx]) begin
                any_req = 1'b1;
                win     = IW'(idx);
            end
        end
        win_oh = '0;
        for (int i = 0; i < nr_of_ports; i++)
            win_oh[nr_of_ports-1-i] = (win == IW'(i));
    end

    always_comb begin
        sel_adr = '0;
        sel_dat = '0;
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        for (int i = 0; i < nr_of_ports; i++) begin
            if (gidx == IW'(i)) begin
                sel_adr = bus.wb_adr_i[(nr_of_ports-1-i)*adr_size +: adr_size];
                sel_dat = bus.wb_dat_i[(nr_of_ports-1-i)*dat_size +: dat_size];
                sel_cyc = cyc_p[i];
                sel_stb = stb_p[i];
            end
        end
        sel_cti = sel_adr[2:0];
    end

    assign busy = (state == BUSY);

    // Classic cycles and end-of-burst release on ack; an abandoned cycle releases immediately.
    assign term = busy && (!sel_cyc ||
                           (bus.m_ack_i && (sel_cti == 3'b000 || sel_cti == 3'b111)));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            gidx        <= '0;
            last        <= IW'(nr_of_ports-1);
            bus.grant_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= BUSY;
                        gidx        <= win;
                        last        <= win;
                        bus.grant_o <= win_oh;
                    end
                end
                BUSY: begin
                    if (term) begin
                        state       <= IDLE;
                        bus.grant_o <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.grant_o <= '0;
                end
            endcase
        end
    end

    // Everything toward the target is gated by the registered state, so reset clears it at once.
    always_comb begin
        bus.m_adr_o = busy ? sel_adr : '0;
        bus.m_dat_o = busy ? sel_dat : '0;
        bus.m_cyc_o = busy & sel_cyc;
        bus.m_stb_o = busy & sel_stb;
        bus.wb_ack_o = '0;
        for (int i = 0; i < nr_of_ports; i++)
            bus.wb_ack_o[nr_of_ports-1-i] = busy && (gidx == IW'(i)) && bus.m_ack_i;
    end

    assign bus.wb_dat_o = {nr_of_ports{bus.m_dat_i}};

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed stimulus for wb_port_arbiter against a cycle-level arbitration model.
module tb_wb_port_arbiter;
    localparam int NP = 3;
    localparam int AS = 36;
    localparam int DS = 36;

    logic wb_clk   = 1'b0;
    logic wb_rst_n = 1'b0;
    always #5 wb_clk = ~wb_clk;

    wb_port_arbiter_if #(.nr_of_ports(NP), .adr_size(AS), .dat_size(DS)) bus ();

    wb_port_arbiter #(.nr_of_ports(NP), .adr_size(AS), .dat_size(DS)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (bus)
    );

    // Per-port stimulus, indexed by port number
    logic [AS-1:0] adr [NP];
    logic [DS-1:0] dat [NP];
    logic          cyc [NP];
    logic          stb [NP];
    logic          ack;
    logic [31:0]   rdat;

    // Reference model: who holds the port and who won last
    bit mbusy;
    int mg;
    int mlast;

    int n_vec = 0;
    int n_bad = 0;

    logic [2:0] cti_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd2, 3'd0};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AS-1:0] mk_adr(input logic [2:0] cti);
        return {30'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), cti};
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.wb_adr_i[(NP-1-p)*AS +: AS] = adr[p];
            bus.wb_dat_i[(NP-1-p)*DS +: DS] = dat[p];
            bus.wb_cyc_i[NP-1-p]            = cyc[p];
            bus.wb_stb_i[NP-1-p]            = stb[p];
        end
        bus.m_ack_i = ack;
        bus.m_dat_i = rdat;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) begin
            adr[p] = '0;
            dat[p] = '0;
            cyc[p] = 1'b0;
            stb[p] = 1'b0;
        end
        ack  = 1'b0;
        rdat = '0;
    endtask

    task automatic rand_inputs();
        for (int p = 0; p < NP; p++) begin
            cyc[p] = ($urandom_range(0, 3) != 0);
            stb[p] = ($urandom_range(0, 3) != 0);
            adr[p] = mk_adr(cti_tab[$urandom_range(0, 5)]);
            dat[p] = {$urandom, 4'($urandom_range(0, 15))};
        end
        ack  = 1'($urandom_range(0, 1));
        rdat = $urandom;
    endtask

    // Arbitration rules applied to the inputs present at a rising edge
    task automatic model_edge();
        logic [2:0] cti;
        if (!mbusy) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (mlast + k) % NP;
                if (cyc[p] && stb[p]) begin
                    mbusy = 1'b1;
                    mg    = p;
                    mlast = p;
                    break;
                end
            end
        end else begin
            cti = adr[mg][2:0];
            if (!cyc[mg] || (ack && (cti == 3'd0 || cti == 3'd7)))
                mbusy = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] e_g;
        logic [NP-1:0] e_ack;
        e_g   = '0;
        e_ack = '0;
        if (mbusy) begin
            e_g[NP-1-mg]   = 1'b1;
            e_ack[NP-1-mg] = ack;
        end
        check("grant", bus.grant_o, e_g);
        check("m_cyc", bus.m_cyc_o, mbusy && cyc[mg]);
        check("m_stb", bus.m_stb_o, mbusy && stb[mg]);
        check("wb_ack", bus.wb_ack_o, e_ack);
        check("m_adr", bus.m_adr_o, mbusy ? adr[mg] : '0);
        check("m_dat", bus.m_dat_o, mbusy ? dat[mg] : '0);
        check("wb_dat", bus.wb_dat_o, {NP{rdat}});
    endtask

    task automatic tick(input bit rnd);
        @(posedge wb_clk);
        if (wb_rst_n)
            model_edge();
        #2;
        if (rnd)
            rand_inputs();
        drive();
        #1;
        compare_all();
    endtask

    initial begin
        clear_inputs();
        drive();
        mbusy = 1'b0;
        mlast = NP - 1;
        mg    = 0;

        #3;
        compare_all();
        #20 wb_rst_n = 1'b1;

        // Single classic write on port 1
        adr[1] = mk_adr(3'd0) | AS'(1 << 5);
        dat[1] = {32'hCAFE_0001, 4'hF};
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        drive();
        tick(0);
        check("single_grant", bus.grant_o, 3'b010);
        check("single_adr", bus.m_adr_o, adr[1]);
        ack  = 1'b1;
        rdat = 32'h1234_5678;
        drive();
        #1;
        check("single_ack", bus.wb_ack_o, 3'b010);
        tick(0);
        check("single_release", bus.grant_o, 3'b000);
        clear_inputs();
        drive();

        // Burst on port 0 while port 2 waits
        tick(0);
        adr[0] = {30'h0000_1000, 1'b0, 2'b01, 3'b010};
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        drive();
        tick(0);
        check("burst_grant", bus.grant_o, 3'b100);
        adr[2] = mk_adr(3'd0);
        cyc[2] = 1'b1;
        stb[2] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            adr[0][2:0] = (b == 3) ? 3'b111 : 3'b010;
            ack  = 1'b1;
            rdat = $urandom;
            drive();
            #1;
            check("burst_ack", bus.wb_ack_o, 3'b100);
            tick(0);
        end
        check("burst_bubble", bus.grant_o, 3'b000);
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        ack    = 1'b0;
        drive();
        tick(0);
        check("burst_next", bus.grant_o, 3'b001);

        // Port 2 abandons its cycle before any ack
        cyc[2] = 1'b0;
        drive();
        #1;
        check("abandon_cyc", bus.m_cyc_o, 1'b0);
        tick(0);
        check("abandon_grant", bus.grant_o, 3'b000);
        check("abandon_ack", bus.wb_ack_o, 3'b000);

        // All ports issue classic reads back to back
        for (int p = 0; p < NP; p++) begin
            adr[p] = mk_adr(3'd0);
            cyc[p] = 1'b1;
            stb[p] = 1'b1;
        end
        ack = 1'b1;
        drive();
        for (int n = 0; n < 12; n++)
            tick(0);

        for (int n = 0; n < 1500; n++)
            tick(1);

        // Reset during a burst beat
        clear_inputs();
        drive();
        tick(0);
        tick(0);
        adr[0] = {30'h0000_2000, 1'b1, 2'b01, 3'b010};
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        drive();
        tick(0);
        check("rst_pre_grant", bus.grant_o, 3'b100);
        ack = 1'b1;
        drive();
        #1;
        wb_rst_n = 1'b0;
        #1;
        check("rst_grant", bus.grant_o, 3'b000);
        check("rst_m_cyc", bus.m_cyc_o, 1'b0);
        check("rst_ack", bus.wb_ack_o, 3'b000);
        mbusy = 1'b0;
        mlast = NP - 1;
        ack   = 1'b0;
        for (int p = 0; p < NP; p++) begin
            adr[p] = mk_adr(3'd0);
            cyc[p] = 1'b1;
            stb[p] = 1'b1;
        end
        drive();
        #2 wb_rst_n = 1'b1;
        tick(0);
        check("rst_first_grant", bus.grant_o, 3'b100);

        for (int n = 0; n < 300; n++)
            tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
